csi2_test_pattern_gen: RTL and testbench
========================================

# csi2_test_pattern_gen

Parametrised Bayer test-pattern source for the CSI-2 transmit path. It produces one 2×2 Bayer quad (R, Gr, Gb, B) per byte-clock cycle from the line/column counters supplied by the timing generator. It generalises the fixed four-pattern generator in three ways: configurable resolution and pixel width, seven patterns including animated ones, and a host-selectable fixed or auto-cycling mode. It sits between the frame timing generator and the RAW packer.

## Interface
Parameters:
- PIXEL_WIDTH, 10: bits per colour sample.
- H_UNITS, 400: active column-counter span per line (640 px RAW10 → 400).
- V_ACTIVE, 480: active lines; line numbering is 1-based.
- FRAMES_PER_PATTERN, 42: frames per pattern in auto mode; ≥1.
- SCROLL_STEP, 4: column units per frame for the scrolling pattern.
- CHECK_LOG2, 5: checker square size is 2^CHECK_LOG2 units/lines.
- RAMP_SHIFT, 1: ramp gain as a left shift of the column counter.

Ports:
- byte_clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-low reset.
- line_number_i  in  12  current line; value 1 marks frame start.
- hori_pixel_count_i  in  12  current column unit.
- auto_cycle_i  in  1  1 = auto-cycle patterns, 0 = use pattern_sel_i.
- pattern_sel_i  in  3  requested pattern in fixed mode.
- pixel_red_o, pixel_green_red_o, pixel_green_blue_o, pixel_blue_o  out  PIXEL_WIDTH each  Bayer quad samples.
- pattern_o  out  3  pattern currently being generated.
- frame_cnt_o  out  16  frames since reset; wraps.

## Operation
- **Frame start.** Asserted on the first cycle where line_number_i == 1 and the previous cycle's value was ≠ 1. It fires exactly once per frame, however long line 1 lasts.
- **Actions on frame start:**
  - frame_cnt_o increments.
  - scroll offset advances by SCROLL_STEP, modulo H_UNITS.
  - Pattern update, auto mode: the dwell counter runs 0..FRAMES_PER_PATTERN-1. On reaching the terminal value it returns to 0 and the pattern advances 0→1→…→6→0.
  - Pattern update, fixed mode: pattern latches pattern_sel_i. The value 7 maps to 0. The dwell counter is held at 0.
- **No mid-frame change.** The pattern never changes mid-frame, so there is no tearing. A change of auto_cycle_i takes effect at the next frame start.
- **Palette** (ordered R,Gr,Gb,B; M = all-ones):
  - RED = M,0,0,0
  - BLUE = 0,0,0,M
  - GREEN = 0,M,M,0
  - WHITE = M,M,M,MSB-only
- **Bars.** Four equal bands with boundaries at E/4, E/2, 3E/4, computed as localparams.
  - Index: coord < E/4 → WHITE; < E/2 → GREEN; < 3E/4 → BLUE; otherwise RED.
  - Coordinates above E also give RED.
- **Patterns:**
  - 0: horizontal bars; coord = line, E = V_ACTIVE.
  - 1: vertical bars; coord = column, E = H_UNITS.
  - 2: solid RED.
  - 3: solid BLUE.
  - 4: grey ramp. All four samples = column << RAMP_SHIFT, saturated to M.
  - 5: checkerboard. WHITE when line[CHECK_LOG2] XOR column[CHECK_LOG2] = 1, else all zero.
  - 6: scrolling vertical bars. Coord = (column + offset), reduced mod H_UNITS by a single conditional subtract; offset < H_UNITS guarantees this is enough.

## Timing
- **Latency.** Pixel outputs are registered: 1 cycle from the line/column inputs to the quad.
- **Frame-start alignment.** The pattern and offset update on the frame-start cycle. The first quad of line 1 therefore uses the new pattern, one cycle later.
- **Reset values.** All pixel outputs 0; pattern_o 0; frame_cnt_o 0; offset 0; dwell 0. The previous-line register resets to 0, so line_number_i == 1 during reset release produces a frame start on the first active cycle.
- **Reset mid-frame.** Outputs clear asynchronously. Generation resumes with pattern 0 on the next active edge; pattern 0 output does not wait for a frame start.
- **Wrap-around.** frame_cnt_o wraps 0xFFFF→0. Offset wraps modulo H_UNITS.
- **Simultaneous events.** If the mode is fixed at the auto-terminal frame, fixed wins and the dwell counter clears.

## Structure
- **Package `tpg_pkg`:**
  - pattern codes PAT_HBARS..PAT_SCROLL;
  - palette constants parameterised by PIXEL_WIDTH;
  - bar-index function.
- **Sub-module `tpg_frame_sequencer`:**
  - frame-start edge detect;
  - frame, dwell and offset counters;
  - pattern register with mode mux.
- **Top level:** the pixel datapath, with one output register stage.

## Test plan
- **Auto cycling.** Auto mode, FRAMES_PER_PATTERN=3, 25 frames → pattern_o steps 0,1,…,6,0 every 3 frames. frame_cnt_o = 25.
- **Line 1 held long.** line_number_i held at 1 for 500 cycles → frame_cnt_o increments once.
- **Fixed mode and mid-frame select.**
  - Fixed mode, pattern_sel_i=5 set mid-frame → pattern_o stays old until the next line 1, then becomes 5.
  - pattern_sel_i=7 → pattern_o=0.
- **Bar and checker spot values:**
  - Pattern 0: line 100 → WHITE (blue = 0x200); line 359 → BLUE; line 360 → RED.
  - Pattern 5: line 0x20, column 0 → WHITE.
- **Ramp and scrolling:**
  - Pattern 4: column 300 → all samples 0x258; column 399 → 0x31E; column 600 (wider H_UNITS test) → saturates to 0x3FF.
  - Pattern 6: after 100 frames (offset 0) column 0 → WHITE; after 25 frames (offset 100) column 0 → GREEN.
- **Reset mid-frame.** Assert reset_i low mid-line in pattern 3 → outputs 0 immediately. After release, the next quad follows pattern 0 and frame_cnt_o = 0.

Source files
------------

// File: rtl/tpg_pkg.sv
// Shared types and helpers for the CSI-2 Bayer test-pattern generator.
package tpg_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PAT_W    = 3;

  typedef enum logic [PAT_W-1:0] {
    PAT_HBARS  = 3'd0,
    PAT_VBARS  = 3'd1,
    PAT_RED    = 3'd2,
    PAT_BLUE   = 3'd3,
    PAT_RAMP   = 3'd4,
    PAT_CHECK  = 3'd5,
    PAT_SCROLL = 3'd6,
    PAT_RSVD   = 3'd7
  } pattern_e;

  typedef enum logic [1:0] {COL_WHITE, COL_GREEN, COL_BLUE, COL_RED} bar_color_e;
  typedef enum logic [1:0] {LANE_R, LANE_GR, LANE_GB, LANE_B} lane_e;

  // One Bayer sample of a palette colour for a w-bit pixel.
  function automatic logic [SAMPLE_W-1:0] palette(bar_color_e c, lane_e lane, int unsigned w);
    logic [SAMPLE_W-1:0] m;
    m = SAMPLE_W'((32'd1 << w) - 32'd1);
    palette = '0;
    case (c)
      COL_WHITE: palette = (lane == LANE_B) ? SAMPLE_W'(32'd1 << (w - 32'd1)) : m;
      COL_GREEN: palette = (lane == LANE_GR || lane == LANE_GB) ? m : '0;
      COL_BLUE:  palette = (lane == LANE_B) ? m : '0;
      COL_RED:   palette = (lane == LANE_R) ? m : '0;
      default:   palette = '0;
    endcase
  endfunction

  // Four-band bar index; anything at or past the last boundary is RED.
  function automatic bar_color_e bar_color(int unsigned coord, int unsigned q1,
                                           int unsigned q2, int unsigned q3);
    if (coord < q1)      bar_color = COL_WHITE;
    else if (coord < q2) bar_color = COL_GREEN;
    else if (coord < q3) bar_color = COL_BLUE;
    else                 bar_color = COL_RED;
  endfunction

endpackage

// File: rtl/tpg_frame_sequencer.sv
// Frame-start detection plus frame, dwell, scroll-offset counters and the pattern register.
module tpg_frame_sequencer import tpg_pkg::*; #(
  parameter int unsigned H_UNITS            = 400,
  parameter int unsigned FRAMES_PER_PATTERN = 42,
  parameter int unsigned SCROLL_STEP        = 4
) (
  input  logic        byte_clk_i,
  input  logic        reset_i,
  input  logic [11:0] line_number_i,
  input  logic        auto_cycle_i,
  input  logic [2:0]  pattern_sel_i,
  output pattern_e    pattern_nxt_c,
  output logic [11:0] offset_nxt_c,
  output pattern_e    pattern_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned DWELL_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

  logic [11:0]        line_prev_q;
  logic [11:0]        offset_q;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt_c;
  logic [12:0]        offset_sum_c;
  logic               frame_start_c;

  assign frame_start_c = (line_number_i == 12'd1) && (line_prev_q != 12'd1);
  assign offset_sum_c  = 13'(offset_q) + 13'(SCROLL_STEP);

  // Next-state values are also consumed by the datapath so line 1 already uses them.
  always_comb begin
    pattern_nxt_c = pattern_o;
    offset_nxt_c  = offset_q;
    dwell_nxt_c   = dwell_q;
    if (frame_start_c) begin
      offset_nxt_c = (offset_sum_c >= 13'(H_UNITS)) ? 12'(offset_sum_c - 13'(H_UNITS))
                                                    : 12'(offset_sum_c);
      if (!auto_cycle_i) begin
        dwell_nxt_c   = '0;
        pattern_nxt_c = (pattern_sel_i == 3'd7) ? PAT_HBARS : pattern_e'(pattern_sel_i);
      end else if (dwell_q == DWELL_W'(FRAMES_PER_PATTERN - 1)) begin
        dwell_nxt_c   = '0;
        pattern_nxt_c = (pattern_o == PAT_SCROLL) ? PAT_HBARS
                                                  : pattern_e'(3'(pattern_o) + 3'd1);
      end else begin
        dwell_nxt_c = dwell_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge byte_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      line_prev_q <= '0;
      offset_q    <= '0;
      dwell_q     <= '0;
      pattern_o   <= PAT_HBARS;
      frame_cnt_o <= '0;
    end else begin
      line_prev_q <= line_number_i;
      offset_q    <= offset_nxt_c;
      dwell_q     <= dwell_nxt_c;
      pattern_o   <= pattern_nxt_c;
      if (frame_start_c) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule

// File: rtl/csi2_test_pattern_gen.sv
// Bayer-quad test-pattern source: pattern sequencer plus a one-stage registered pixel datapath.
module csi2_test_pattern_gen import tpg_pkg::*; #(
  parameter int unsigned PIXEL_WIDTH        = 10,
  parameter int unsigned H_UNITS            = 400,
  parameter int unsigned V_ACTIVE           = 480,
  parameter int unsigned FRAMES_PER_PATTERN = 42,
  parameter int unsigned SCROLL_STEP        = 4,
  parameter int unsigned CHECK_LOG2         = 5,
  parameter int unsigned RAMP_SHIFT         = 1
) (
  input  logic                   byte_clk_i,
  input  logic                   reset_i,
  input  logic [11:0]            line_number_i,
  input  logic [11:0]            hori_pixel_count_i,
  input  logic                   auto_cycle_i,
  input  logic [2:0]             pattern_sel_i,
  output logic [PIXEL_WIDTH-1:0] pixel_red_o,
  output logic [PIXEL_WIDTH-1:0] pixel_green_red_o,
  output logic [PIXEL_WIDTH-1:0] pixel_green_blue_o,
  output logic [PIXEL_WIDTH-1:0] pixel_blue_o,
  output logic [2:0]             pattern_o,
  output logic [15:0]            frame_cnt_o
);

  localparam int unsigned V_Q1 = V_ACTIVE / 4;
  localparam int unsigned V_Q2 = V_ACTIVE / 2;
  localparam int unsigned V_Q3 = (3 * V_ACTIVE) / 4;
  localparam int unsigned H_Q1 = H_UNITS / 4;
  localparam int unsigned H_Q2 = H_UNITS / 2;
  localparam int unsigned H_Q3 = (3 * H_UNITS) / 4;
  localparam logic [PIXEL_WIDTH-1:0] PIX_MAX = '1;

  pattern_e         pattern_nxt_c, pattern_q;
  logic [11:0]      offset_nxt_c;
  logic [12:0]      scroll_sum_c, scroll_coord_c;
  logic [31:0]      ramp_c;
  logic [PIXEL_WIDTH-1:0] ramp_sat_c, flat_c;
  logic             check_on_c, use_pal_c;
  bar_color_e       color_c;

  tpg_frame_sequencer #(
    .H_UNITS           (H_UNITS),
    .FRAMES_PER_PATTERN(FRAMES_PER_PATTERN),
    .SCROLL_STEP       (SCROLL_STEP)
  ) u_seq (
    .byte_clk_i   (byte_clk_i),
    .reset_i      (reset_i),
    .line_number_i(line_number_i),
    .auto_cycle_i (auto_cycle_i),
    .pattern_sel_i(pattern_sel_i),
    .pattern_nxt_c(pattern_nxt_c),
    .offset_nxt_c (offset_nxt_c),
    .pattern_o    (pattern_q),
    .frame_cnt_o  (frame_cnt_o)
  );

  assign pattern_o = pattern_q;

  // Offset is always below H_UNITS, so one conditional subtract wraps the sum.
  assign scroll_sum_c   = 13'(hori_pixel_count_i) + 13'(offset_nxt_c);
  assign scroll_coord_c = (scroll_sum_c >= 13'(H_UNITS)) ? scroll_sum_c - 13'(H_UNITS) : scroll_sum_c;
  assign ramp_c         = 32'(hori_pixel_count_i) << RAMP_SHIFT;
  assign ramp_sat_c     = (ramp_c > 32'(PIX_MAX)) ? PIX_MAX : PIXEL_WIDTH'(ramp_c);
  assign check_on_c     = line_number_i[CHECK_LOG2] ^ hori_pixel_count_i[CHECK_LOG2];

  // Either a palette colour or a flat grey level drives all four samples.
  always_comb begin
    color_c   = COL_WHITE;
    use_pal_c = 1'b1;
    flat_c    = '0;
    case (pattern_nxt_c)
      PAT_VBARS:  color_c = bar_color(32'(hori_pixel_count_i), H_Q1, H_Q2, H_Q3);
      PAT_RED:    color_c = COL_RED;
      PAT_BLUE:   color_c = COL_BLUE;
      PAT_RAMP: begin
        use_pal_c = 1'b0;
        flat_c    = ramp_sat_c;
      end
      PAT_CHECK:  use_pal_c = check_on_c;
      PAT_SCROLL: color_c = bar_color(32'(scroll_coord_c), H_Q1, H_Q2, H_Q3);
      default:    color_c = bar_color(32'(line_number_i), V_Q1, V_Q2, V_Q3);
    endcase
  end

  always_ff @(posedge byte_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pixel_red_o        <= '0;
      pixel_green_red_o  <= '0;
      pixel_green_blue_o <= '0;
      pixel_blue_o       <= '0;
    end else begin
      pixel_red_o        <= use_pal_c ? PIXEL_WIDTH'(palette(color_c, LANE_R,  PIXEL_WIDTH)) : flat_c;
      pixel_green_red_o  <= use_pal_c ? PIXEL_WIDTH'(palette(color_c, LANE_GR, PIXEL_WIDTH)) : flat_c;
      pixel_green_blue_o <= use_pal_c ? PIXEL_WIDTH'(palette(color_c, LANE_GB, PIXEL_WIDTH)) : flat_c;
      pixel_blue_o       <= use_pal_c ? PIXEL_WIDTH'(palette(color_c, LANE_B,  PIXEL_WIDTH)) : flat_c;
    end
  end

endmodule

// File: tb/tb_csi2_test_pattern_gen.sv
// Scoreboard bench for csi2_test_pattern_gen: directed vectors, expected quads queued, monitor compares.
module tb_csi2_test_pattern_gen;

  typedef logic [58:0] obs_t;   // {R,Gr,Gb,B,pattern,frame_cnt}

  localparam logic [39:0] Q_W = {10'h3FF, 10'h3FF, 10'h3FF, 10'h200};
  localparam logic [39:0] Q_G = {10'h000, 10'h3FF, 10'h3FF, 10'h000};
  localparam logic [39:0] Q_B = {10'h000, 10'h000, 10'h000, 10'h3FF};
  localparam logic [39:0] Q_R = {10'h3FF, 10'h000, 10'h000, 10'h000};
  localparam logic [39:0] Q_Z = 40'h0;

  logic        byte_clk_i;
  logic        reset_i;
  logic [11:0] line_number_i;
  logic [11:0] hori_pixel_count_i;
  logic        auto_cycle_i;
  logic [2:0]  pattern_sel_i;
  logic [9:0]  pixel_red_o, pixel_green_red_o, pixel_green_blue_o, pixel_blue_o;
  logic [2:0]  pattern_o;
  logic [15:0] frame_cnt_o;

  int    total = 0;
  int    bad   = 0;
  int    nfr   = 0;
  logic  chk_req = 1'b0;
  obs_t  exp_q[$];
  string name_q[$];

  csi2_test_pattern_gen #(.FRAMES_PER_PATTERN(3)) dut (
    .byte_clk_i        (byte_clk_i),
    .reset_i           (reset_i),
    .line_number_i     (line_number_i),
    .hori_pixel_count_i(hori_pixel_count_i),
    .auto_cycle_i      (auto_cycle_i),
    .pattern_sel_i     (pattern_sel_i),
    .pixel_red_o       (pixel_red_o),
    .pixel_green_red_o (pixel_green_red_o),
    .pixel_green_blue_o(pixel_green_blue_o),
    .pixel_blue_o      (pixel_blue_o),
    .pattern_o         (pattern_o),
    .frame_cnt_o       (frame_cnt_o)
  );

  initial byte_clk_i = 1'b0;
  always #5 byte_clk_i = ~byte_clk_i;

  function automatic obs_t observed();
    return {pixel_red_o, pixel_green_red_o, pixel_green_blue_o, pixel_blue_o, pattern_o, frame_cnt_o};
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Column-coordinate bars with H_UNITS = 400.
  function automatic logic [39:0] bar_h(input int c);
    if (c < 100) return Q_W;
    if (c < 200) return Q_G;
    if (c < 300) return Q_B;
    return Q_R;
  endfunction

  // Quad at line 1, column 0 for each pattern while the scroll offset is below 100.
  function automatic logic [39:0] line1_quad(input int pat);
    case (pat)
      2: return Q_R;
      3: return Q_B;
      4: return Q_Z;
      5: return Q_Z;
      default: return Q_W;
    endcase
  endfunction

  // Scoreboard monitor: one expected entry per flagged input cycle.
  initial begin
    obs_t e;
    string n;
    forever begin
      @(posedge byte_clk_i);
      if (chk_req) begin
        #1;
        if (exp_q.size() == 0) begin
          cmp("underflow", observed(), '1);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          cmp(n, observed(), e);
        end
      end
    end
  end

  task automatic cycle(input int line, input int col);
    @(negedge byte_clk_i);
    line_number_i      = 12'(line);
    hori_pixel_count_i = 12'(col);
    chk_req            = 1'b0;
  endtask

  task automatic check(input string nm, input int line, input int col,
                       input logic [39:0] q, input int pat);
    @(negedge byte_clk_i);
    line_number_i      = 12'(line);
    hori_pixel_count_i = 12'(col);
    exp_q.push_back({q, 3'(pat), 16'(nfr)});
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  task automatic frame(input string nm, input int pat, input logic [39:0] q);
    nfr++;
    check(nm, 1, 0, q, pat);
    cycle(2, 0);
  endtask

  task automatic do_reset();
    @(negedge byte_clk_i);
    reset_i            = 1'b0;
    line_number_i      = 12'd0;
    hori_pixel_count_i = 12'd0;
    chk_req            = 1'b0;
    @(negedge byte_clk_i);
    @(negedge byte_clk_i);
    cmp("reset_state", observed(), '0);
    reset_i = 1'b1;
    nfr     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i            = 1'b0;
    line_number_i      = 12'd0;
    hori_pixel_count_i = 12'd0;
    auto_cycle_i       = 1'b1;
    pattern_sel_i      = 3'd0;

    // Auto cycling, three frames per pattern.
    do_reset();
    for (int k = 1; k <= 25; k++) frame($sformatf("auto_f%0d", k), (k / 3) % 7, line1_quad((k / 3) % 7));

    // Line 1 held for 500 cycles counts as one frame.
    nfr++;
    for (int i = 0; i < 499; i++) cycle(1, 0);
    check("line1_hold", 1, 0, Q_W, 1);
    check("line1_after", 2, 0, Q_W, 1);

    // Fixed mode: mid-frame select waits for the next frame start; 7 maps to 0.
    auto_cycle_i  = 1'b0;
    pattern_sel_i = 3'd0;
    do_reset();
    frame("fix_p0", 0, Q_W);
    cycle(2, 0);
    pattern_sel_i = 3'd5;
    check("midframe_sel", 3, 0, Q_W, 0);
    frame("fix_p5", 5, Q_Z);
    pattern_sel_i = 3'd7;
    frame("fix_p7", 0, Q_W);

    // Spot values per pattern.
    pattern_sel_i = 3'd0;
    frame("hb_frame", 0, Q_W);
    check("hb_100", 100, 0, Q_W, 0);
    check("hb_359", 359, 0, Q_B, 0);
    check("hb_360", 360, 0, Q_R, 0);
    pattern_sel_i = 3'd1;
    frame("vb_frame", 1, Q_W);
    check("vb_99", 2, 99, Q_W, 1);
    check("vb_100", 2, 100, Q_G, 1);
    check("vb_399", 2, 399, Q_R, 1);
    check("vb_450", 2, 450, Q_R, 1);
    pattern_sel_i = 3'd2;
    frame("solid_red", 2, Q_R);
    pattern_sel_i = 3'd3;
    frame("solid_blue", 3, Q_B);
    pattern_sel_i = 3'd4;
    frame("ramp_frame", 4, Q_Z);
    check("ramp_300", 5, 300, {4{10'h258}}, 4);
    check("ramp_399", 5, 399, {4{10'h31E}}, 4);
    check("ramp_600", 5, 600, {4{10'h3FF}}, 4);
    pattern_sel_i = 3'd5;
    frame("chk_frame", 5, Q_Z);
    check("chk_20_0", 32, 0, Q_W, 5);
    check("chk_20_20", 32, 32, Q_Z, 5);
    check("chk_0_20", 0, 32, Q_W, 5);

    // Scrolling bars: offset advances 4 per frame and wraps at 400.
    pattern_sel_i = 3'd6;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      frame($sformatf("scroll_f%0d", k), 6, bar_h((4 * k) % 400));
      if (k == 25) begin
        check("scroll_off100_c0", 2, 0, Q_G, 6);
        check("scroll_off100_c350", 2, 350, Q_W, 6);
      end
    end
    check("scroll_off0_c0", 2, 0, Q_W, 6);
    check("scroll_off0_c350", 2, 350, Q_R, 6);

    // Reset mid-line clears outputs at once; generation resumes on pattern 0.
    pattern_sel_i = 3'd3;
    frame("pre_rst_blue", 3, Q_B);
    cycle(5, 10);
    @(posedge byte_clk_i);
    #2;
    reset_i = 1'b0;
    #1;
    cmp("rst_async_clear", observed(), '0);
    nfr = 0;
    @(negedge byte_clk_i);
    line_number_i = 12'd5;
    hori_pixel_count_i = 12'd0;
    @(negedge byte_clk_i);
    reset_i = 1'b1;
    check("post_rst_p0", 5, 0, Q_W, 0);

    cycle(0, 0);
    cycle(0, 0);
    cmp("scoreboard_drained", obs_t'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
